spi_flash_wr_guard: RTL and testbench
=====================================

Name: spi_flash_wr_guard

Overview:
- Sits directly upstream of the Pico-to-flash SPI pass-through bridge, between the RP2040 SPI pins and the bridge inputs.
- Synchronises Pico SCK/CS/MOSI into clk and forwards them unchanged.
- Decodes the first byte (opcode) of every transaction.
- When writes are locked, defeats flash write-enable commands by clocking one extra SCK pulse before CS rises. The flash then rejects the command as not byte-aligned, so no program or erase can follow.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the input synchronisers (minimum 2).
- INJ_HALF, 4: clk cycles per half-period of the injected SCK pulse (minimum 1).
- OPC_WREN, 8'h06: first blocked opcode.
- OPC_WREN_VOL, 8'h50: second blocked opcode (volatile status-register write enable).

Ports:
- clk  in  1  system clock; everything is sampled on its rising edge
- rst  in  1  asynchronous, active-high reset
- pico_sck_i  in  1  raw Pico SCK, SPI mode 0
- pico_cs_i  in  1  raw Pico CS, active low
- pico_mosi_i  in  1  raw Pico MOSI
- wr_unlock  in  1  1 = blocked opcodes pass; sampled at the 8th SCK rise of each transaction
- out_sck  out  1  SCK to the bridge
- out_cs  out  1  CS to the bridge
- out_mosi  out  1  MOSI to the bridge
- last_opcode  out  8  opcode of the most recent transaction
- opcode_valid  out  1  1-cycle pulse when last_opcode updates
- blocked  out  1  1-cycle pulse when an opcode is classified as blocked
- blocked_cnt  out  16  count of blocked transactions; saturates at 16'hFFFF
- overrun  out  1  sticky flag: Pico re-asserted CS during an injection
- overrun_clr  in  1  clears overrun; a set event in the same cycle wins
- last_addr  out  24  see Optional Feature
- addr_valid  out  1  see Optional Feature

Behaviour:
- Reset values: out_cs=1, out_sck=0, out_mosi=0, last_opcode=0, opcode_valid=0, blocked=0, blocked_cnt=0, overrun=0, last_addr=0, addr_valid=0. Synchroniser flops reset to cs=1, sck=0, mosi=0. FSM resets to IDLE.
- Let s_sck, s_cs and s_mosi be the synchroniser outputs.
- Edge detection uses one extra register on s_sck: sck_rise = s_sck & ~sck_d.
- Forwarding: outside injection, out_sck/out_cs/out_mosi are registered copies of s_sck/s_cs/s_mosi. Latency from raw pin to output is SYNC_STAGES+1 cycles, identical for all three signals, so their relative timing is preserved.
- FSM states:
  - IDLE: when s_cs falls, clear the bit counter and go to OPC.
  - OPC: on each sck_rise, shift s_mosi in MSB-first and increment the counter.
    - On the 8th rise: latch last_opcode and pulse opcode_valid on the following cycle.
    - If the opcode equals OPC_WREN or OPC_WREN_VOL and wr_unlock=0, pulse blocked, increment blocked_cnt and go to BLK. Otherwise go to PASS.
    - If s_cs rises before 8 bits, return to IDLE and leave last_opcode unchanged.
  - PASS: forward transparently. When s_cs rises, go to IDLE.
  - BLK: keep forwarding SCK and MOSI. When s_cs rises, suppress the rise: hold out_cs=0 and go to INJ_HI.
  - INJ_HI: hold out_sck=1 for INJ_HALF cycles, with out_mosi=0, then go to INJ_LO.
  - INJ_LO: hold out_sck=0 for INJ_HALF cycles, then go to INJ_END.
  - INJ_END: hold out_cs=0 for 1 cycle, then release out_cs=1 and go to IDLE.
- Injection length: in total, out_cs rises 2*INJ_HALF+1 cycles later than s_cs.
- Injection overrun: if s_cs falls during INJ_* or INJ_END, set overrun. Finish the injection normally, then hold out_cs=1 until s_cs goes high, discarding that transaction, then go to IDLE.
- Blocked transactions that carry more than 8 bits are forwarded in full, plus the extra pulse. The flash ignores them either way.
- Asserting rst mid-transaction immediately drives out_cs=1 and out_sck=0.

Optional Feature:
- Macro: SPI_FLASH_WR_GUARD_ADDR_EN.
- When defined, the 24-bit address is captured for transactions in PASS whose opcode is 8'h02, 8'h20 or 8'hD8:
  - The next 24 SCK-rise bits are captured MSB-first.
  - last_addr updates on the 32nd bit, with a 1-cycle addr_valid pulse.
  - If CS rises earlier, nothing is updated.
- When undefined, last_addr is tied to 0, addr_valid is tied to 0, and the capture logic is absent.

Test Plan:
- Opcode 8'h03 with 24-bit address 0x001000, wr_unlock=0 -> outputs match the inputs delayed by 3 cycles; last_opcode=8'h03, one opcode_valid pulse, blocked_cnt=0.
- Opcode 8'h06, wr_unlock=0, INJ_HALF=4 -> 9 out_sck rises inside the out_cs low window; out_cs rises 9 cycles after s_cs; blocked pulses once; blocked_cnt=1.
- Opcode 8'h06, wr_unlock=1 -> exactly 8 out_sck rises; no blocked pulse; blocked_cnt unchanged.
- Pico CS re-asserted 2 cycles after the CS rise of a blocked 8'h50 -> overrun=1; that transaction produces no out_cs low; overrun_clr returns overrun to 0.
- rst asserted after the 4th bit of 8'h02 -> out_cs=1 asynchronously; all outputs at reset values; the next 8'h05 transaction decodes with last_opcode=8'h05.
- With SPI_FLASH_WR_GUARD_ADDR_EN defined: 8'h20 followed by address 0x0AB000, wr_unlock=1 -> last_addr=24'h0AB000 with one addr_valid pulse.

Source files
------------

// File: rtl/spi_flash_wr_guard.sv
// spi_flash_wr_guard: write-enable guard in front of the Pico-to-flash SPI bridge.
// Synchronises the Pico SPI pins into clk and forwards them. It decodes the first
// byte of each transaction. While writes are locked, a WREN or WREN_VOL opcode gets
// one extra SCK pulse before CS rises, so the flash discards the command.
// Optional build macro SPI_FLASH_WR_GUARD_ADDR_EN adds 24-bit address capture for
// program/erase opcodes (8'h02, 8'h20, 8'hD8).
module spi_flash_wr_guard #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned INJ_HALF     = 4,
  parameter logic [7:0]  OPC_WREN     = 8'h06,
  parameter logic [7:0]  OPC_WREN_VOL = 8'h50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pico_sck_i,
  input  logic        pico_cs_i,
  input  logic        pico_mosi_i,
  input  logic        wr_unlock,
  output logic        out_sck,
  output logic        out_cs,
  output logic        out_mosi,
  output logic [7:0]  last_opcode,
  output logic        opcode_valid,
  output logic        blocked,
  output logic [15:0] blocked_cnt,
  output logic        overrun,
  input  logic        overrun_clr,
  output logic [23:0] last_addr,
  output logic        addr_valid
);

  localparam int unsigned IW = (INJ_HALF > 1) ? $clog2(INJ_HALF) : 1;
  localparam logic [IW-1:0] INJ_LAST = IW'(INJ_HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_OPC, S_PASS, S_BLK, S_INJ_HI, S_INJ_LO, S_INJ_END, S_DRAIN
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic s_sck, s_cs, s_mosi;
  logic sck_d, cs_d;
  logic sck_rise, cs_fall;

  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [6:0]    shift, shift_nx;
  logic [IW-1:0] inj_cnt, inj_cnt_nx;
  logic          ovr_pend, pend_nx;
  logic          sck_nx, cs_nx, mosi_nx;
  logic          opc_done, blk_evt, ovr_set;
  logic [7:0]    opc_word;
  logic          opc_blocked;

  // Input synchronisers; CS resets to its idle (high) level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], pico_sck_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], pico_cs_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], pico_mosi_i};
    end
  end

  assign s_sck  = sck_sync[SYNC_STAGES-1];
  assign s_cs   = cs_sync[SYNC_STAGES-1];
  assign s_mosi = mosi_sync[SYNC_STAGES-1];

  // Delayed copies for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_d <= 1'b0;
      cs_d  <= 1'b1;
    end else begin
      sck_d <= s_sck;
      cs_d  <= s_cs;
    end
  end

  assign sck_rise    = s_sck & ~sck_d;
  assign cs_fall     = ~s_cs & cs_d;
  assign opc_word    = {shift, s_mosi};
  assign opc_blocked = ((opc_word == OPC_WREN) || (opc_word == OPC_WREN_VOL)) && !wr_unlock;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state, counters and the next value of each forwarded pin
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
    inj_cnt_nx = inj_cnt;
    pend_nx    = ovr_pend;
    sck_nx     = s_sck;
    cs_nx      = s_cs;
    mosi_nx    = s_mosi;
    opc_done   = 1'b0;
    blk_evt    = 1'b0;
    ovr_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!s_cs) begin
          bit_cnt_nx = '0;
          state_nx   = S_OPC;
        end
      end
      S_OPC: begin
        if (s_cs) begin
          state_nx = S_IDLE;
        end else if (sck_rise) begin
          shift_nx   = opc_word[6:0];
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            opc_done = 1'b1;
            if (opc_blocked) begin
              blk_evt  = 1'b1;
              state_nx = S_BLK;
            end else begin
              state_nx = S_PASS;
            end
          end
        end
      end
      S_PASS: begin
        if (s_cs) state_nx = S_IDLE;
      end
      S_BLK: begin
        // Swallow the CS rise; this cycle already drives the first high half of the pulse
        if (s_cs) begin
          cs_nx      = 1'b0;
          sck_nx     = 1'b1;
          mosi_nx    = 1'b0;
          inj_cnt_nx = '0;
          pend_nx    = 1'b0;
          state_nx   = S_INJ_HI;
        end
      end
      S_INJ_HI: begin
        cs_nx   = 1'b0;
        mosi_nx = 1'b0;
        if (inj_cnt == INJ_LAST) begin
          sck_nx     = 1'b0;
          inj_cnt_nx = '0;
          state_nx   = S_INJ_LO;
        end else begin
          sck_nx     = 1'b1;
          inj_cnt_nx = inj_cnt + IW'(1);
        end
      end
      S_INJ_LO: begin
        cs_nx   = 1'b0;
        sck_nx  = 1'b0;
        mosi_nx = 1'b0;
        if (inj_cnt == INJ_LAST) begin
          inj_cnt_nx = '0;
          state_nx   = S_INJ_END;
        end else begin
          inj_cnt_nx = inj_cnt + IW'(1);
        end
      end
      S_INJ_END: begin
        cs_nx    = 1'b1;
        sck_nx   = 1'b0;
        mosi_nx  = 1'b0;
        state_nx = (ovr_pend || !s_cs) ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        cs_nx   = 1'b1;
        sck_nx  = 1'b0;
        mosi_nx = 1'b0;
        if (s_cs) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (cs_fall && (state == S_INJ_HI || state == S_INJ_LO || state == S_INJ_END)) begin
      ovr_set = 1'b1;
      pend_nx = 1'b1;
    end
  end

  // Counters and registered pin outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      shift    <= '0;
      inj_cnt  <= '0;
      ovr_pend <= 1'b0;
      out_sck  <= 1'b0;
      out_cs   <= 1'b1;
      out_mosi <= 1'b0;
    end else begin
      bit_cnt  <= bit_cnt_nx;
      shift    <= shift_nx;
      inj_cnt  <= inj_cnt_nx;
      ovr_pend <= pend_nx;
      out_sck  <= sck_nx;
      out_cs   <= cs_nx;
      out_mosi <= mosi_nx;
    end
  end

  // Opcode reporting, block counter and the sticky overrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_opcode  <= '0;
      opcode_valid <= 1'b0;
      blocked      <= 1'b0;
      blocked_cnt  <= '0;
      overrun      <= 1'b0;
    end else begin
      opcode_valid <= opc_done;
      blocked      <= blk_evt;
      if (opc_done) last_opcode <= opc_word;
      if (blk_evt && (blocked_cnt != 16'hFFFF)) blocked_cnt <= blocked_cnt + 16'd1;
      if (ovr_set)          overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

`ifdef SPI_FLASH_WR_GUARD_ADDR_EN
  logic        addr_arm, addr_arm_nx;
  logic [4:0]  addr_cnt, addr_cnt_nx;
  logic [22:0] addr_sh, addr_sh_nx;
  logic        addr_evt;
  logic [23:0] addr_word;

  assign addr_word = {addr_sh, s_mosi};

  // Arm on a passing program/erase opcode, then collect the next 24 bits
  always_comb begin
    addr_arm_nx = addr_arm;
    addr_cnt_nx = addr_cnt;
    addr_sh_nx  = addr_sh;
    addr_evt    = 1'b0;
    if (opc_done && !opc_blocked) begin
      addr_arm_nx = (opc_word == 8'h02) || (opc_word == 8'h20) || (opc_word == 8'hD8);
      addr_cnt_nx = '0;
    end else if (state == S_PASS && addr_arm) begin
      if (s_cs) begin
        addr_arm_nx = 1'b0;
      end else if (sck_rise) begin
        addr_sh_nx  = addr_word[22:0];
        addr_cnt_nx = addr_cnt + 5'd1;
        if (addr_cnt == 5'd23) begin
          addr_evt    = 1'b1;
          addr_arm_nx = 1'b0;
        end
      end
    end else if (state != S_PASS) begin
      addr_arm_nx = 1'b0;
    end
  end

  // Address capture registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_arm   <= 1'b0;
      addr_cnt   <= '0;
      addr_sh    <= '0;
      last_addr  <= '0;
      addr_valid <= 1'b0;
    end else begin
      addr_arm   <= addr_arm_nx;
      addr_cnt   <= addr_cnt_nx;
      addr_sh    <= addr_sh_nx;
      addr_valid <= addr_evt;
      if (addr_evt) last_addr <= addr_word;
    end
  end
`else
  assign last_addr  = '0;
  assign addr_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spi_flash_wr_guard.sv
// Testbench for spi_flash_wr_guard: table vectors, randomized transactions against a
// transaction-level model, and hand sequences for overrun, async reset and address capture.
module tb_spi_flash_wr_guard;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned INJ_HALF    = 4;
  localparam int LAT_FWD = SYNC_STAGES + 1;
  localparam int LAT_INJ = LAT_FWD + 2 * INJ_HALF + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pico_sck_i = 1'b0;
  logic        pico_cs_i = 1'b1;
  logic        pico_mosi_i = 1'b0;
  logic        wr_unlock = 1'b0;
  logic        overrun_clr = 1'b0;
  logic        out_sck, out_cs, out_mosi;
  logic [7:0]  last_opcode;
  logic        opcode_valid, blocked, overrun, addr_valid;
  logic [15:0] blocked_cnt;
  logic [23:0] last_addr;

  spi_flash_wr_guard #(.SYNC_STAGES(SYNC_STAGES), .INJ_HALF(INJ_HALF)) dut (
    .clk(clk), .rst(rst),
    .pico_sck_i(pico_sck_i), .pico_cs_i(pico_cs_i), .pico_mosi_i(pico_mosi_i),
    .wr_unlock(wr_unlock),
    .out_sck(out_sck), .out_cs(out_cs), .out_mosi(out_mosi),
    .last_opcode(last_opcode), .opcode_valid(opcode_valid),
    .blocked(blocked), .blocked_cnt(blocked_cnt),
    .overrun(overrun), .overrun_clr(overrun_clr),
    .last_addr(last_addr), .addr_valid(addr_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Monitor: event counters sampled on the falling edge
  int rises = 0, ov_cnt = 0, blk_cnt = 0, av_cnt = 0, ovr_hi = 0, cs_low = 0, fwd_err = 0;
  logic prev_sck = 1'b0;
  logic fwd_en = 1'b0;
  logic [2:0] h0 = 3'b010, h1 = 3'b010, h2 = 3'b010;

  always @(posedge clk) begin
    h2 <= h1;
    h1 <= h0;
    h0 <= {pico_sck_i, pico_cs_i, pico_mosi_i};
  end

  always @(negedge clk) begin
    if (!out_cs && out_sck && !prev_sck) rises++;
    if (opcode_valid) ov_cnt++;
    if (blocked) blk_cnt++;
    if (addr_valid) av_cnt++;
    if (overrun) ovr_hi++;
    if (!out_cs) cs_low++;
    if (fwd_en && ({out_sck, out_cs, out_mosi} != h2)) fwd_err++;
    prev_sck = out_sck;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: only the decoded opcode matters
  logic [7:0]  m_last_opc = 8'h00;
  logic [15:0] m_cnt = 16'h0000;
  int m_ov, m_blk, m_rises, m_lat;

  task automatic model_txn(input logic [39:0] data, input int nbits, input logic unlock);
    logic [7:0] opc;
    m_ov = 0;
    m_blk = 0;
    if (nbits >= 8) begin
      opc = 8'((data >> (nbits - 8)) & 40'hFF);
      m_last_opc = opc;
      m_ov = 1;
      if ((opc == 8'h06 || opc == 8'h50) && !unlock) m_blk = 1;
      if (m_blk == 1 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    m_rises = nbits + m_blk;
    m_lat = (m_blk == 1) ? LAT_INJ : LAT_FWD;
  endtask

  task automatic spi_bit(input logic b);
    pico_mosi_i = b;
    repeat (3) @(posedge clk);
    #1;
    pico_sck_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pico_sck_i = 1'b0;
  endtask

  int d_rises, d_ov, d_blk, d_av, d_fwd, lat;

  task automatic run_txn(input logic [39:0] data, input int nbits, input logic unlock,
                         input logic chk_fwd);
    int r0, o0, b0, a0, f0;
    @(posedge clk);
    #1;
    r0 = rises; o0 = ov_cnt; b0 = blk_cnt; a0 = av_cnt; f0 = fwd_err;
    fwd_en = chk_fwd;
    wr_unlock = unlock;
    pico_cs_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = nbits - 1; i >= 0; i--) spi_bit(data[i]);
    repeat (3) @(posedge clk);
    #1;
    pico_cs_i = 1'b1;
    pico_mosi_i = 1'b0;
    lat = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_cs) break;
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    fwd_en = 1'b0;
    d_rises = rises - r0; d_ov = ov_cnt - o0; d_blk = blk_cnt - b0;
    d_av = av_cnt - a0; d_fwd = fwd_err - f0;
  endtask

  task automatic check_txn(input string p, input logic [7:0] e_opc, input int e_ov,
                           input int e_blk, input logic [15:0] e_cnt, input int e_rises,
                           input int e_lat);
    chk({p, "_opcode"}, 64'(last_opcode), 64'(e_opc));
    chk({p, "_opc_valid"}, 64'(d_ov), 64'(e_ov));
    chk({p, "_blk_pulse"}, 64'(d_blk), 64'(e_blk));
    chk({p, "_blk_cnt"}, 64'(blocked_cnt), 64'(e_cnt));
    chk({p, "_sck_rises"}, 64'(d_rises), 64'(e_rises));
    chk({p, "_cs_latency"}, 64'(lat), 64'(e_lat));
    if (e_blk == 0) chk({p, "_fwd"}, 64'(d_fwd), 64'd0);
  endtask

  typedef struct {
    logic [39:0] data;
    int          nbits;
    logic        unlock;
    logic [7:0]  exp_opc;
    int          exp_ov;
    int          exp_blk;
    logic [15:0] exp_cnt;
    int          exp_rises;
    int          exp_lat;
  } vec_t;

  vec_t tbl[9];
  int nb_tab[6] = '{4, 8, 8, 16, 32, 40};

  initial begin
    int o0, s0, z0, k;
    int sel, nb;
    logic [7:0] opc;
    logic [39:0] d;
    logic ul;

    tbl[0] = '{40'h0003001000, 32, 1'b0, 8'h03, 1, 0, 16'd0, 32, 3};
    tbl[1] = '{40'h0000000006,  8, 1'b0, 8'h06, 1, 1, 16'd1,  9, 12};
    tbl[2] = '{40'h0000000006,  8, 1'b1, 8'h06, 1, 0, 16'd1,  8, 3};
    tbl[3] = '{40'h0000000050,  8, 1'b0, 8'h50, 1, 1, 16'd2,  9, 12};
    tbl[4] = '{40'h00000006A5, 16, 1'b0, 8'h06, 1, 1, 16'd3, 17, 12};
    tbl[5] = '{40'h0000000005,  8, 1'b0, 8'h05, 1, 0, 16'd3,  8, 3};
    tbl[6] = '{40'h0000000014,  5, 1'b0, 8'h05, 0, 0, 16'd3,  5, 3};
    tbl[7] = '{40'h0000000050,  8, 1'b1, 8'h50, 1, 0, 16'd3,  8, 3};
    tbl[8] = '{40'h00D8123456, 32, 1'b0, 8'hD8, 1, 0, 16'd3, 32, 3};

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_state",
        64'({out_cs, out_sck, out_mosi, last_opcode, opcode_valid, blocked, blocked_cnt,
             overrun, last_addr, addr_valid}),
        64'({1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 24'h000000, 1'b0}));
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 9; i++) begin
      model_txn(tbl[i].data, tbl[i].nbits, tbl[i].unlock);
      run_txn(tbl[i].data, tbl[i].nbits, tbl[i].unlock, tbl[i].exp_blk == 0);
      check_txn($sformatf("tbl%0d", i), tbl[i].exp_opc, tbl[i].exp_ov, tbl[i].exp_blk,
                tbl[i].exp_cnt, tbl[i].exp_rises, tbl[i].exp_lat);
    end

    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: opc = 8'h06;
        1: opc = 8'h50;
        2: opc = 8'h03;
        3: opc = 8'h02;
        4: opc = 8'h20;
        5: opc = 8'hD8;
        default: opc = 8'($urandom);
      endcase
      nb = nb_tab[$urandom_range(0, 5)];
      d = {8'($urandom), 32'($urandom)};
      if (nb >= 8) d = (d & ((40'd1 << (nb - 8)) - 40'd1)) | (40'(opc) << (nb - 8));
      else d = d & ((40'd1 << nb) - 40'd1);
      ul = 1'($urandom_range(0, 1));
      model_txn(d, nb, ul);
      run_txn(d, nb, ul, m_blk == 0);
      check_txn($sformatf("rnd%0d", t), m_last_opc, m_ov, m_blk, m_cnt, m_rises, m_lat);
    end

    // Overrun: CS re-asserted 2 cycles after the CS rise of a blocked 8'h50
    for (int pass = 0; pass < 2; pass++) begin
      @(posedge clk);
      #1;
      wr_unlock = 1'b0;
      overrun_clr = (pass == 1);
      s0 = ovr_hi;
      pico_cs_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 7; i >= 0; i--) spi_bit(i == 6 || i == 4);
      repeat (3) @(posedge clk);
      #1;
      pico_cs_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      pico_cs_i = 1'b0;
      model_txn(40'h50, 8, 1'b0);
      k = 0;
      while (k < 40) begin
        @(negedge clk);
        if (out_cs) break;
        k++;
      end
      chk($sformatf("ovr%0d_inj_done", pass), 64'(out_cs), 64'd1);
      z0 = cs_low;
      o0 = ov_cnt;
      @(posedge clk);
      #1;
      for (int i = 7; i >= 0; i--) spi_bit(i != 6 && i != 5);
      repeat (3) @(posedge clk);
      #1;
      pico_cs_i = 1'b1;
      pico_mosi_i = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk($sformatf("ovr%0d_no_cs_low", pass), 64'(cs_low - z0), 64'd0);
      chk($sformatf("ovr%0d_no_decode", pass), 64'(ov_cnt - o0), 64'd0);
      chk($sformatf("ovr%0d_opcode", pass), 64'(last_opcode), 64'(m_last_opc));
      chk($sformatf("ovr%0d_blk_cnt", pass), 64'(blocked_cnt), 64'(m_cnt));
      if (pass == 0) begin
        chk("ovr0_flag", 64'(overrun), 64'd1);
        #1;
        overrun_clr = 1'b1;
        @(posedge clk);
        #1;
        overrun_clr = 1'b0;
        @(negedge clk);
        chk("ovr0_cleared", 64'(overrun), 64'd0);
      end else begin
        chk("ovr1_set_beats_clr", 64'(ovr_hi - s0), 64'd1);
        chk("ovr1_flag_after", 64'(overrun), 64'd0);
        #1;
        overrun_clr = 1'b0;
      end
    end

    // Asynchronous reset during the 4th bit of 8'h02
    @(posedge clk);
    #1;
    pico_cs_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) spi_bit(1'b0);
    pico_mosi_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pico_sck_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pre_sck_high", 64'({out_cs, out_sck}), 64'({1'b0, 1'b1}));
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_pins", 64'({out_cs, out_sck}), 64'({1'b1, 1'b0}));
    chk("rst_all_outputs",
        64'({out_cs, out_sck, out_mosi, last_opcode, opcode_valid, blocked, blocked_cnt,
             overrun, last_addr, addr_valid}),
        64'({1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 24'h000000, 1'b0}));
    pico_sck_i = 1'b0;
    pico_cs_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    m_cnt = 16'h0000;
    m_last_opc = 8'h00;
    model_txn(40'h05, 8, 1'b0);
    run_txn(40'h05, 8, 1'b0, 1'b1);
    check_txn("post_rst", m_last_opc, m_ov, m_blk, m_cnt, m_rises, m_lat);

`ifdef SPI_FLASH_WR_GUARD_ADDR_EN
    run_txn(40'h0020_0AB000, 32, 1'b1, 1'b1);
    chk("addr_value", 64'(last_addr), 64'h0AB000);
    chk("addr_pulse", 64'(d_av), 64'd1);
    run_txn(40'h0002_0F00, 20, 1'b1, 1'b1);
    chk("addr_short_kept", 64'(last_addr), 64'h0AB000);
    chk("addr_short_pulse", 64'(d_av), 64'd0);
`else
    run_txn(40'h0020_0AB000, 32, 1'b1, 1'b1);
    chk("addr_tied_value", 64'(last_addr), 64'd0);
    chk("addr_tied_pulse", 64'(d_av), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
